// File: rtl/battle_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : battle_turn_ctrl
// Description : Battle turn sequencer (attack -> apply -> dodge) owning both
//               HP counters and the win/lose verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module battle_turn_ctrl #(
  parameter logic [7:0]  ENEMY_HP_INIT  = 8'd100,
  parameter logic [7:0]  PLAYER_HP_INIT = 8'd20,
  parameter int unsigned DODGE_CYCLES   = 1000,
  parameter logic [7:0]  HIT_DAMAGE     = 8'd4,
  parameter logic [7:0]  HIT_COOLDOWN   = 8'd50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start_battle,
  input  logic       i_atk_pass,
  input  logic [7:0] i_atk_damage,
  input  logic       i_hit,
  output logic       o_atk_start,
  output logic       o_dodge_active,
  output logic [2:0] o_phase,
  output logic [7:0] o_enemy_hp,
  output logic [7:0] o_player_hp,
  output logic [7:0] o_turn_count,
  output logic       o_win,
  output logic       o_lose
);

  localparam logic [15:0] c_DODGE_LAST = 16'(DODGE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ATK_REQ  = 3'd1,
    S_ATK_WAIT = 3'd2,
    S_APPLY    = 3'd3,
    S_DODGE    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } phase_t;

  phase_t      r_state;
  phase_t      w_next;
  logic [7:0]  r_enemy_hp;
  logic [7:0]  r_player_hp;
  logic [7:0]  r_turn_count;
  logic [7:0]  r_damage;
  logic [15:0] r_timer;
  logic [7:0]  r_cooldown;

  logic [7:0]  w_enemy_sub;
  logic [7:0]  w_player_sub;
  logic [7:0]  w_player_new;
  logic        w_hit_take;
  logic        w_restart;

  assign w_enemy_sub  = (r_enemy_hp > r_damage) ? (r_enemy_hp - r_damage) : 8'd0;
  assign w_player_sub = (r_player_hp > HIT_DAMAGE) ? (r_player_hp - HIT_DAMAGE) : 8'd0;
  assign w_hit_take   = (r_state == S_DODGE) && i_hit && (r_cooldown == 8'd0);
  assign w_player_new = w_hit_take ? w_player_sub : r_player_hp;
  assign w_restart    = i_start_battle &&
                        ((r_state == S_IDLE) || (r_state == S_WIN) || (r_state == S_LOSE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (i_start_battle) w_next = S_ATK_REQ;
      end
      S_ATK_REQ: begin
        if (!i_atk_pass) w_next = S_ATK_WAIT;
      end
      S_ATK_WAIT: begin
        if (i_atk_pass) w_next = S_APPLY;
      end
      S_APPLY: begin
        w_next = (w_enemy_sub == 8'd0) ? S_WIN : S_DODGE;
      end
      S_DODGE: begin
        // A hit landing on the final timer cycle is applied before the exit decision
        if (w_player_new == 8'd0)   w_next = S_LOSE;
        else if (r_timer == 16'd0)  w_next = S_ATK_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enemy_hp   <= ENEMY_HP_INIT;
      r_player_hp  <= PLAYER_HP_INIT;
      r_turn_count <= 8'd0;
      r_damage     <= 8'd0;
      r_timer      <= 16'd0;
      r_cooldown   <= 8'd0;
    end else begin
      if (w_restart) begin
        r_enemy_hp   <= ENEMY_HP_INIT;
        r_player_hp  <= PLAYER_HP_INIT;
        r_turn_count <= 8'd0;
      end
      if ((r_state == S_ATK_WAIT) && i_atk_pass) begin
        r_damage <= i_atk_damage;
      end
      if (r_state == S_APPLY) begin
        r_enemy_hp <= w_enemy_sub;
        if (r_turn_count != 8'hFF) r_turn_count <= r_turn_count + 8'd1;
        r_timer    <= c_DODGE_LAST;
        r_cooldown <= 8'd0;
      end
      if (r_state == S_DODGE) begin
        if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
        if (w_hit_take) begin
          r_player_hp <= w_player_sub;
          r_cooldown  <= HIT_COOLDOWN;
        end else if (r_cooldown != 8'd0) begin
          r_cooldown <= r_cooldown - 8'd1;
        end
      end
    end
  end

  assign o_phase        = r_state;
  assign o_atk_start    = (r_state == S_ATK_REQ);
  assign o_dodge_active = (r_state == S_DODGE);
  assign o_win          = (r_state == S_WIN);
  assign o_lose         = (r_state == S_LOSE);
  assign o_enemy_hp     = r_enemy_hp;
  assign o_player_hp    = r_player_hp;
  assign o_turn_count   = r_turn_count;

endmodule
`default_nettype wire

// File: tb/tb_battle_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_battle_turn_ctrl
// Description : Directed self-checking bench for battle_turn_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_battle_turn_ctrl;

  logic       clk;
  logic       reset;
  logic       i_start_battle;
  logic       i_atk_pass;
  logic [7:0] i_atk_damage;
  logic       i_hit;
  logic       o_atk_start;
  logic       o_dodge_active;
  logic [2:0] o_phase;
  logic [7:0] o_enemy_hp;
  logic [7:0] o_player_hp;
  logic [7:0] o_turn_count;
  logic       o_win;
  logic       o_lose;

  int n_cmp = 0;
  int n_err = 0;

  battle_turn_ctrl u_dut (
    .clk            (clk),
    .reset          (reset),
    .i_start_battle (i_start_battle),
    .i_atk_pass     (i_atk_pass),
    .i_atk_damage   (i_atk_damage),
    .i_hit          (i_hit),
    .o_atk_start    (o_atk_start),
    .o_dodge_active (o_dodge_active),
    .o_phase        (o_phase),
    .o_enemy_hp     (o_enemy_hp),
    .o_player_hp    (o_player_hp),
    .o_turn_count   (o_turn_count),
    .o_win          (o_win),
    .o_lose         (o_lose)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] p, input int max);
    int n;
    n = 0;
    while (o_phase !== p && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(o_phase), 32'(p));
  endtask

  // Gauge block model: drop pass, hold it low a cycle, then return it with the damage
  task automatic do_attack(input logic [7:0] dmg, input logic [2:0] exp_phase,
                           input logic [7:0] exp_enemy, input logic [7:0] exp_turn);
    wait_phase("atk_req", 3'd1, 1100);
    chk("atk_start_hi", 32'(o_atk_start), 32'd1);
    i_atk_pass = 1'b0;
    tick();
    chk("atk_wait", 32'(o_phase), 32'd2);
    chk("atk_start_lo", 32'(o_atk_start), 32'd0);
    tick();
    i_atk_damage = dmg;
    i_atk_pass   = 1'b1;
    tick();
    chk("apply", 32'(o_phase), 32'd3);
    i_atk_damage = 8'hAA;
    tick();
    chk("post_apply_phase", 32'(o_phase), 32'(exp_phase));
    chk("enemy_hp", 32'(o_enemy_hp), 32'(exp_enemy));
    chk("turn_count", 32'(o_turn_count), 32'(exp_turn));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int drops;
    int hit_at [3];
    logic [7:0] prev;

    reset = 1'b0; i_start_battle = 1'b0; i_atk_pass = 1'b1;
    i_atk_damage = 8'd0; i_hit = 1'b0;
    #2 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_phase", 32'(o_phase), 32'd0);
    chk("rst_enemy", 32'(o_enemy_hp), 32'd100);
    chk("rst_player", 32'(o_player_hp), 32'd20);
    chk("rst_turn", 32'(o_turn_count), 32'd0);
    chk("rst_atk_start", 32'(o_atk_start), 32'd0);
    chk("rst_dodge", 32'(o_dodge_active), 32'd0);
    chk("rst_winlose", 32'({o_win, o_lose}), 32'd0);

    i_start_battle = 1'b1; tick(); i_start_battle = 1'b0;
    chk("start_phase", 32'(o_phase), 32'd1);
    chk("start_atk", 32'(o_atk_start), 32'd1);
    chk("start_enemy", 32'(o_enemy_hp), 32'd100);
    chk("start_player", 32'(o_player_hp), 32'd20);
    tick();
    chk("atk_req_hold", 32'(o_phase), 32'd1);

    do_attack(8'd20, 3'd4, 8'd80, 8'd1);
    chk("dodge_active", 32'(o_dodge_active), 32'd1);

    // Held hit for 120 cycles with a 50-cycle cooldown
    n = 0; drops = 0; prev = o_player_hp; i_hit = 1'b1;
    for (int k = 0; k < 120; k++) begin
      tick();
      n++;
      if (o_player_hp != prev) begin
        if (drops < 3) hit_at[drops] = k;
        drops++;
        prev = o_player_hp;
      end
    end
    i_hit = 1'b0;
    chk("hit_count", 32'(drops), 32'd3);
    chk("hit0_cycle", 32'(hit_at[0]), 32'd0);
    chk("hit1_cycle", 32'(hit_at[1]), 32'd51);
    chk("hit2_cycle", 32'(hit_at[2]), 32'd102);
    chk("hit_player", 32'(o_player_hp), 32'd8);
    while (o_phase == 3'd4 && n < 1100) begin
      tick();
      n++;
    end
    chk("dodge_len", 32'(n), 32'd1000);
    chk("dodge_exit", 32'(o_phase), 32'd1);

    do_attack(8'd20, 3'd4, 8'd60, 8'd2);
    do_attack(8'd20, 3'd4, 8'd40, 8'd3);
    do_attack(8'd20, 3'd4, 8'd20, 8'd4);
    do_attack(8'd20, 3'd5, 8'd0, 8'd5);
    chk("win_flag", 32'(o_win), 32'd1);
    chk("win_no_dodge", 32'(o_dodge_active), 32'd0);
    i_hit = 1'b1; tick(); tick(); i_hit = 1'b0;
    chk("win_hold", 32'(o_phase), 32'd5);
    chk("win_player_frozen", 32'(o_player_hp), 32'd8);

    i_start_battle = 1'b1; tick(); i_start_battle = 1'b0;
    chk("rewin_phase", 32'(o_phase), 32'd1);
    chk("rewin_enemy", 32'(o_enemy_hp), 32'd100);
    chk("rewin_player", 32'(o_player_hp), 32'd20);
    chk("rewin_turn", 32'(o_turn_count), 32'd0);
    do_attack(8'd20, 3'd4, 8'd80, 8'd1);
    do_attack(8'd255, 3'd5, 8'd0, 8'd2);
    chk("sat_win", 32'(o_win), 32'd1);

    // Lose: bring player to 4 HP, then hit on the final timer cycle
    i_start_battle = 1'b1; tick(); i_start_battle = 1'b0;
    do_attack(8'd20, 3'd4, 8'd80, 8'd1);
    for (int k = 0; k < 999; k++) begin
      i_hit = (k == 0 || k == 60 || k == 120 || k == 180);
      i_start_battle = (k == 300);
      tick();
    end
    i_hit = 1'b0; i_start_battle = 1'b0;
    chk("last_cycle_phase", 32'(o_phase), 32'd4);
    chk("last_cycle_player", 32'(o_player_hp), 32'd4);
    chk("dodge_ignores_start", 32'(o_turn_count), 32'd1);
    i_hit = 1'b1; tick(); i_hit = 1'b0;
    chk("lose_phase", 32'(o_phase), 32'd6);
    chk("lose_flag", 32'(o_lose), 32'd1);
    chk("lose_player", 32'(o_player_hp), 32'd0);
    chk("lose_dodge", 32'(o_dodge_active), 32'd0);

    i_start_battle = 1'b1; tick(); i_start_battle = 1'b0;
    chk("relose_phase", 32'(o_phase), 32'd1);
    chk("relose_player", 32'(o_player_hp), 32'd20);
    chk("relose_enemy", 32'(o_enemy_hp), 32'd100);
    chk("relose_turn", 32'(o_turn_count), 32'd0);

    do_attack(8'd0, 3'd4, 8'd100, 8'd1);
    i_hit = 1'b1; tick(); i_hit = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_phase", 32'(o_phase), 32'd0);
    chk("async_rst_dodge", 32'(o_dodge_active), 32'd0);
    chk("async_rst_player", 32'(o_player_hp), 32'd20);
    chk("async_rst_turn", 32'(o_turn_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", 32'(o_phase), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
